// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- central stall/flush controller for the 5-stage in-order
// pipeline (IF, ID, EX, MEM, WB).
//
// Each cycle the controller resolves the hazard events into pipeline-register
// write enables and flushes. The priority order, highest first, is:
//   exception, D-cache busy, divider busy, branch mispredict, load-use,
//   I-cache busy.
// A two-state FSM (RUN/DROP) remembers a wrong-path fetch that is still
// outstanding after a redirect, so that the fetch can be discarded when it
// returns.
//
// All outputs are combinational from the inputs and the FSM state. Only the
// FSM state and the optional counters are registered.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the StallCnt/DropCnt
// performance counters. When the macro is undefined, both counters read 0.
//
// Ports:
//   clk             clock
//   rst             asynchronous, active-low reset
//   IF_ICacheBusy   instruction fetch outstanding, no valid instruction
//   ID_LoadUse      ID needs the result of the load now in EX
//   EX_DivBusy      multi-cycle divider in EX is not done
//   EX_BranchFail   mispredict resolved in EX; the redirect PC is presented now
//   MEM_DCacheBusy  data access in MEM is not complete
//   MEM_Exception   exception/eret commits in MEM; the vector PC is presented now
//   PC_Wr, ID_Wr, EX_Wr, MEM_Wr          register write enables
//   ID_Flush, EX_Flush, MEM_Flush, WB_Flush  load a bubble (dominates Wr)
//   IF_DropFetch    discard the instruction returned by the in-flight fetch
//   StallCnt        cycles with PC_Wr=0 outside reset
//   DropCnt         cycles with IF_DropFetch=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IF_ICacheBusy,
  input  logic                 ID_LoadUse,
  input  logic                 EX_DivBusy,
  input  logic                 EX_BranchFail,
  input  logic                 MEM_DCacheBusy,
  input  logic                 MEM_Exception,
  output logic                 PC_Wr,
  output logic                 ID_Wr,
  output logic                 EX_Wr,
  output logic                 MEM_Wr,
  output logic                 ID_Flush,
  output logic                 EX_Flush,
  output logic                 MEM_Flush,
  output logic                 WB_Flush,
  output logic                 IF_DropFetch,
  output logic [CNT_WIDTH-1:0] StallCnt,
  output logic [CNT_WIDTH-1:0] DropCnt
);

  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_e;

  state_e state_q, state_d;

  // A redirect is an exception, or a mispredict that wins the priority chain.
  // A mispredict hidden behind a D-cache or divider stall is not a redirect
  // yet; it is seen again once the stall clears.
  logic redirect;
  assign redirect = MEM_Exception |
                    (~MEM_DCacheBusy & ~EX_DivBusy & EX_BranchFail);

  // NOTE: state registers use non-blocking assignments so that every
  // always_ff samples the pre-edge values; combinational logic uses blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the
    // if/case below can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    PC_Wr        = 1'b1;
    ID_Wr        = 1'b1;
    EX_Wr        = 1'b1;
    MEM_Wr       = 1'b1;
    ID_Flush     = 1'b0;
    EX_Flush     = 1'b0;
    MEM_Flush    = 1'b0;
    WB_Flush     = 1'b0;
    IF_DropFetch = 1'b0;

    if (MEM_Exception) begin
      ID_Flush  = 1'b1;
      EX_Flush  = 1'b1;
      MEM_Flush = 1'b1;
      WB_Flush  = 1'b1;
    end else if (MEM_DCacheBusy) begin
      PC_Wr    = 1'b0;
      ID_Wr    = 1'b0;
      EX_Wr    = 1'b0;
      MEM_Wr   = 1'b0;
      WB_Flush = 1'b1;
    end else if (EX_DivBusy) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EX_Wr     = 1'b0;
      MEM_Flush = 1'b1;
    end else if (EX_BranchFail) begin
      // The delay slot in ID moves on to EX; only the IF->ID register is killed.
      ID_Flush = 1'b1;
    end else if (ID_LoadUse) begin
      // ID is held, not flushed, even if the fetch is also busy.
      PC_Wr    = 1'b0;
      ID_Wr    = 1'b0;
      EX_Flush = 1'b1;
    end else if (IF_ICacheBusy) begin
      PC_Wr    = 1'b0;
      ID_Flush = 1'b1;
    end

    unique case (state_q)
      RUN: begin
        // The fetch still outstanding at a redirect belongs to the old path.
        if (redirect && IF_ICacheBusy) state_d = DROP;
      end
      DROP: begin
        IF_DropFetch = 1'b1;
        ID_Flush     = 1'b1;
        if (!redirect) PC_Wr = 1'b0;
        // The first non-busy cycle is the one returning the wrong-path word.
        // A redirect in that cycle leaves no fetch outstanding, so return to RUN.
        if (!IF_ICacheBusy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (!rst) begin
      PC_Wr        = 1'b0;
      ID_Wr        = 1'b0;
      EX_Wr        = 1'b0;
      MEM_Wr       = 1'b0;
      ID_Flush     = 1'b0;
      EX_Flush     = 1'b0;
      MEM_Flush    = 1'b0;
      WB_Flush     = 1'b0;
      IF_DropFetch = 1'b0;
      state_d      = RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, drop_cnt_q;

  // Both counters wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (!PC_Wr)       stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (IF_DropFetch) drop_cnt_q  <= drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign StallCnt = stall_cnt_q;
  assign DropCnt  = drop_cnt_q;
`else
  assign StallCnt = '0;
  assign DropCnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Inputs are driven 1 time unit after the rising edge. The combinational
// outputs and the counters are sampled on the falling edge. Expected outputs
// come from a hand-written vector table and pass through a scoreboard queue.
// Counter expectations come from a small model that accumulates the expected
// PC_Wr and IF_DropFetch values.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CW = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic rst, icb, lu, div, bf, dcb, exc;
  } in_t;

  typedef struct packed {
    logic pc, id, ex, mem, idf, exf, memf, wbf, drop;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic IF_ICacheBusy = 1'b0, ID_LoadUse = 1'b0, EX_DivBusy = 1'b0;
  logic EX_BranchFail = 1'b0, MEM_DCacheBusy = 1'b0, MEM_Exception = 1'b0;
  logic PC_Wr, ID_Wr, EX_Wr, MEM_Wr;
  logic ID_Flush, EX_Flush, MEM_Flush, WB_Flush, IF_DropFetch;
  logic [CW-1:0] StallCnt, DropCnt;

  hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ICacheBusy(IF_ICacheBusy), .ID_LoadUse(ID_LoadUse),
    .EX_DivBusy(EX_DivBusy), .EX_BranchFail(EX_BranchFail),
    .MEM_DCacheBusy(MEM_DCacheBusy), .MEM_Exception(MEM_Exception),
    .PC_Wr(PC_Wr), .ID_Wr(ID_Wr), .EX_Wr(EX_Wr), .MEM_Wr(MEM_Wr),
    .ID_Flush(ID_Flush), .EX_Flush(EX_Flush), .MEM_Flush(MEM_Flush),
    .WB_Flush(WB_Flush), .IF_DropFetch(IF_DropFetch),
    .StallCnt(StallCnt), .DropCnt(DropCnt)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  out_t   exp_q[$];
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_drop  = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, and compare on the
  // falling edge. Counter values at that point cover all earlier cycles.
  task automatic apply(input vec_t v);
    out_t e, act;
    @(posedge clk);
    #1;
    {rst, IF_ICacheBusy, ID_LoadUse, EX_DivBusy, EX_BranchFail,
     MEM_DCacheBusy, MEM_Exception} = v.i;
    exp_q.push_back(v.o);
    @(negedge clk);
    act = {PC_Wr, ID_Wr, EX_Wr, MEM_Wr, ID_Flush, EX_Flush, MEM_Flush,
           WB_Flush, IF_DropFetch};
    if (exp_q.size() == 0) begin
      check({v.name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({v.name, " outputs"}, 32'(act), 32'(e));
      check({v.name, " StallCnt"}, 32'(StallCnt),
            PERF ? 32'(v.i.rst ? m_stall : '0) : 32'd0);
      check({v.name, " DropCnt"}, 32'(DropCnt),
            PERF ? 32'(v.i.rst ? m_drop : '0) : 32'd0);
      if (!v.i.rst) begin
        m_stall = '0;
        m_drop  = '0;
      end else begin
        if (!e.pc)  m_stall = m_stall + 1'b1;
        if (e.drop) m_drop  = m_drop + 1'b1;
      end
    end
  endtask

  // Input order:  rst icb lu div bf dcb exc
  // Output order: pc id ex mem | idf exf memf wbf | drop
  vec_t vecs[$];

  initial begin
    vec_t v;
    vecs = '{
      '{"reset",        7'b0_111111, 9'b0000_0000_0},
      '{"idle",         7'b1_000000, 9'b1111_0000_0},
      '{"lu_icb",       7'b1_110000, 9'b0011_0100_0},
      '{"dcb_bf1",      7'b1_000110, 9'b0000_0001_0},
      '{"dcb_bf2",      7'b1_000110, 9'b0000_0001_0},
      '{"dcb_bf3",      7'b1_000110, 9'b0000_0001_0},
      '{"bf_after_dcb", 7'b1_000100, 9'b1111_1000_0},
      '{"div",          7'b1_001000, 9'b0001_0010_0},
      '{"icb",          7'b1_100000, 9'b0111_1000_0},
      '{"exc",          7'b1_000001, 9'b1111_1111_0},
      '{"exc_dcb",      7'b1_000011, 9'b1111_1111_0},
      '{"bf_icb",       7'b1_100100, 9'b1111_1000_0},
      '{"drop_c2",      7'b1_100000, 9'b0111_1000_1},
      '{"drop_c3",      7'b1_100000, 9'b0111_1000_1},
      '{"drop_c4",      7'b1_100000, 9'b0111_1000_1},
      '{"drop_c5",      7'b1_100000, 9'b0111_1000_1},
      '{"drop_exit",    7'b1_000000, 9'b0111_1000_1},
      '{"back_run",     7'b1_000000, 9'b1111_0000_0},
      '{"bf_icb_2",     7'b1_100100, 9'b1111_1000_0},
      '{"drop_1st",     7'b1_100000, 9'b0111_1000_1},
      '{"drop_exc",     7'b1_100001, 9'b1111_1111_1},
      '{"drop_stay",    7'b1_100000, 9'b0111_1000_1},
      '{"drop_lu",      7'b1_110000, 9'b0011_1100_1},
      '{"drop_exit_bf", 7'b1_000100, 9'b1111_1000_1},
      '{"run_again",    7'b1_000000, 9'b1111_0000_0},
      '{"bf_icb_3",     7'b1_100100, 9'b1111_1000_0},
      '{"rst_in_drop",  7'b0_100000, 9'b0000_0000_0},
      '{"after_rst",    7'b1_100000, 9'b0111_1000_0},
      '{"exc_icb",      7'b1_100001, 9'b1111_1111_0},
      '{"drop_dcb",     7'b1_100010, 9'b0000_1001_1},
      '{"drop_exit_2",  7'b1_000000, 9'b0111_1000_1},
      '{"idle_end",     7'b1_000000, 9'b1111_0000_0}
    };

    foreach (vecs[k]) apply(vecs[k]);

    // Stall-counter wrap: 17 stalled cycles after a reset wrap a 4-bit
    // counter to 1.
    apply('{"cnt_rst", 7'b0_000000, 9'b0000_0000_0});
    for (int k = 0; k < 17; k++) apply('{"cnt_stall", 7'b1_100000, 9'b0111_1000_0});
    apply('{"cnt_idle", 7'b1_000000, 9'b1111_0000_0});
    check("stall_wrap", 32'(StallCnt), PERF ? 32'd1 : 32'd0);
    check("drop_after_wrap", 32'(DropCnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
